selfcomp_leak_monitor: RTL and testbench

Downstream checker for the self-composed SE pair. It consumes the two SE output streams (result/valid per copy) that are driven by identical stimulus, and measures per-operation completion latency of each copy. It flags a timing leak when the copies complete in different cycles, and a functional mismatch when their results differ. Its flags drive `timingLeak`, `timingLeakDone` and `bothValid` at the self-composition tester top.

---
 rtl/selfcomp_pkg.sv | 17 +
 rtl/selfcomp_leak_monitor_sat_counter.sv | 29 ++
 rtl/selfcomp_leak_monitor.sv | 162 ++++++++++++++++
 tb/tb_selfcomp_leak_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/selfcomp_pkg.sv
// rtl/selfcomp_pkg.sv - shared types and default constants for the self-composition leak checker
package selfcomp_pkg;

    // Judgement states of one operation
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BOTH = 3'd1,
        ST_WAIT_ONE  = 3'd2,   // copy 2 done, waiting for copy 1
        ST_WAIT_TWO  = 3'd3,   // copy 1 done, waiting for copy 2
        ST_DONE      = 3'd4
    } leak_state_e;

    localparam int DEF_WIDTH   = 128;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/selfcomp_leak_monitor_sat_counter.sv
// rtl/selfcomp_leak_monitor_sat_counter.sv - saturating up-counter with clear
module sat_counter
    import selfcomp_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear and increment together load 1, so a fresh count starts at the cycle it is launched
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// rtl/selfcomp_leak_monitor.sv - per-operation latency/skew/result comparison of two SE copies
module selfcomp_leak_monitor
    import selfcomp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_fire,
    input  logic             io_out_validOne,
    input  logic             io_out_validTwo,
    input  logic [WIDTH-1:0] io_out_resultOne,
    input  logic [WIDTH-1:0] io_out_resultTwo,
    input  logic             io_out_ready,
    output logic             bothValid,
    output logic             timingLeak,
    output logic             timingLeakDone,
    output logic             resultMismatch,
    output logic             protocolErr,
    output logic [CNT_W-1:0] latOne,
    output logic [CNT_W-1:0] latTwo,
    output logic [CNT_W-1:0] skew
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LP_MAX     = {1'b0, {CNT_W{1'b1}}};

    leak_state_e      r_state;
    logic [WIDTH-1:0] r_hold;
    logic [CNT_W-1:0] r_lat_one, r_lat_two, r_skew;
    logic             r_leak, r_leak_done, r_mismatch, r_proto_err;

    logic             w_done_one, w_done_two, w_start, w_single, w_skew_start, w_busy;
    logic [CNT_W-1:0] w_cnt, w_skew_cnt, w_first_lat, w_other_lat;
    logic [CNT_W:0]   w_sum;

    assign w_done_one   = io_out_validOne & io_out_ready;
    assign w_done_two   = io_out_validTwo & io_out_ready;
    assign w_start      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && io_in_fire;
    assign w_single     = (r_state == ST_WAIT_ONE) || (r_state == ST_WAIT_TWO);
    assign w_busy       = w_single || (r_state == ST_WAIT_BOTH);
    assign w_skew_start = (r_state == ST_WAIT_BOTH) && (w_done_one ^ w_done_two);

    // Latency of the copy that never arrived: timeout window on top of the first one's latency
    assign w_first_lat = (r_state == ST_WAIT_TWO) ? r_lat_one : r_lat_two;
    assign w_sum       = {1'b0, LP_TIMEOUT} + {1'b0, w_first_lat};
    assign w_other_lat = (w_sum > LP_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clr   (w_start),
        .i_inc   (w_start | w_busy),
        .o_count (w_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_skew_cnt (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clr   (w_start | w_skew_start),
        .i_inc   (w_skew_start | w_single),
        .o_count (w_skew_cnt)
    );

    // A fire while an operation is in flight is dropped but remembered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (io_in_fire && w_busy) begin
            r_proto_err <= 1'b1;
        end
    end

    // Operation judgement: latch latencies, skew and verdict flags as completions arrive
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_lat_one   <= '0;
            r_lat_two   <= '0;
            r_skew      <= '0;
            r_leak      <= 1'b0;
            r_leak_done <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (io_in_fire) begin
                        r_state     <= ST_WAIT_BOTH;
                        r_skew      <= '0;
                        r_leak_done <= 1'b0;
                    end
                end
                ST_WAIT_BOTH: begin
                    if (w_done_one && w_done_two) begin
                        r_state     <= ST_DONE;
                        r_lat_one   <= w_cnt;
                        r_lat_two   <= w_cnt;
                        r_leak_done <= 1'b1;
                        if (io_out_resultOne != io_out_resultTwo) r_mismatch <= 1'b1;
                    end else if (w_done_one) begin
                        r_state   <= ST_WAIT_TWO;
                        r_lat_one <= w_cnt;
                        r_hold    <= io_out_resultOne;
                    end else if (w_done_two) begin
                        r_state   <= ST_WAIT_ONE;
                        r_lat_two <= w_cnt;
                        r_hold    <= io_out_resultTwo;
                    end else if (w_cnt == LP_TIMEOUT) begin
                        r_state     <= ST_DONE;
                        r_leak_done <= 1'b1;
                    end
                end
                ST_WAIT_TWO: begin
                    if (w_done_two) begin
                        r_state     <= ST_DONE;
                        r_lat_two   <= w_cnt;
                        r_skew      <= w_skew_cnt;
                        r_leak      <= 1'b1;
                        r_leak_done <= 1'b1;
                        if (r_hold != io_out_resultTwo) r_mismatch <= 1'b1;
                    end else if (w_skew_cnt == LP_TIMEOUT) begin
                        r_state     <= ST_DONE;
                        r_lat_two   <= w_other_lat;
                        r_skew      <= LP_TIMEOUT;
                        r_leak      <= 1'b1;
                        r_leak_done <= 1'b1;
                    end
                end
                ST_WAIT_ONE: begin
                    if (w_done_one) begin
                        r_state     <= ST_DONE;
                        r_lat_one   <= w_cnt;
                        r_skew      <= w_skew_cnt;
                        r_leak      <= 1'b1;
                        r_leak_done <= 1'b1;
                        if (r_hold != io_out_resultOne) r_mismatch <= 1'b1;
                    end else if (w_skew_cnt == LP_TIMEOUT) begin
                        r_state     <= ST_DONE;
                        r_lat_one   <= w_other_lat;
                        r_skew      <= LP_TIMEOUT;
                        r_leak      <= 1'b1;
                        r_leak_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bothValid      = io_out_validOne & io_out_validTwo;
    assign timingLeak     = r_leak;
    assign timingLeakDone = r_leak_done;
    assign resultMismatch = r_mismatch;
    assign protocolErr    = r_proto_err;
    assign latOne         = r_lat_one;
    assign latTwo         = r_lat_two;
    assign skew           = r_skew;

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// tb/tb_selfcomp_leak_monitor.sv - self-checking bench for selfcomp_leak_monitor
module tb_selfcomp_leak_monitor;

    localparam int W  = 128;
    localparam int CW = 8;
    localparam int TO = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_in_fire, io_out_validOne, io_out_validTwo, io_out_ready;
    logic [W-1:0]  io_out_resultOne, io_out_resultTwo;
    logic          bothValid, timingLeak, timingLeakDone, resultMismatch, protocolErr;
    logic [CW-1:0] latOne, latTwo, skew;

    selfcomp_leak_monitor #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_fire       (io_in_fire),
        .io_out_validOne  (io_out_validOne),
        .io_out_validTwo  (io_out_validTwo),
        .io_out_resultOne (io_out_resultOne),
        .io_out_resultTwo (io_out_resultTwo),
        .io_out_ready     (io_out_ready),
        .bothValid        (bothValid),
        .timingLeak       (timingLeak),
        .timingLeakDone   (timingLeakDone),
        .resultMismatch   (resultMismatch),
        .protocolErr      (protocolErr),
        .latOne           (latOne),
        .latTwo           (latTwo),
        .skew             (skew)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: timestamps of fire and of each copy's completion
    bit           m_busy;
    int           m_t, m_tf, m_t1, m_t2;
    logic [W-1:0] m_r1, m_r2;
    int           m_lat1, m_lat2, m_skew;
    bit           m_leak, m_done, m_mism, m_perr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_t = 0; m_tf = 0; m_t1 = -1; m_t2 = -1;
        m_lat1 = 0; m_lat2 = 0; m_skew = 0;
        m_leak = 0; m_done = 0; m_mism = 0; m_perr = 0;
    endtask

    task automatic model_finish();
        m_busy = 0;
        m_done = 1;
    endtask

    task automatic model_step(input bit f, input bit d1, input bit d2,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        int rel, first;
        if (!m_busy) begin
            if (f) begin
                m_busy = 1; m_tf = m_t; m_t1 = -1; m_t2 = -1;
                m_done = 0; m_skew = 0;
            end
        end else begin
            rel = m_t - m_tf;
            if (f) m_perr = 1;
            if (d1 && m_t1 < 0) begin m_t1 = rel; m_r1 = a; m_lat1 = rel; end
            if (d2 && m_t2 < 0) begin m_t2 = rel; m_r2 = b; m_lat2 = rel; end
            if (m_t1 >= 0 && m_t2 >= 0) begin
                m_skew = (m_t1 > m_t2) ? m_t1 - m_t2 : m_t2 - m_t1;
                if (m_t1 != m_t2) m_leak = 1;
                if (m_r1 != m_r2) m_mism = 1;
                model_finish();
            end else if (m_t1 < 0 && m_t2 < 0) begin
                if (rel == TO) model_finish();
            end else begin
                first = (m_t1 >= 0) ? m_t1 : m_t2;
                if (rel - first == TO) begin
                    if (m_t1 < 0) m_lat1 = (TO + first > 255) ? 255 : TO + first;
                    else          m_lat2 = (TO + first > 255) ? 255 : TO + first;
                    m_skew = TO;
                    m_leak = 1;
                    model_finish();
                end
            end
        end
        m_t++;
    endtask

    task automatic check_model();
        chk("latOne", int'(latOne), m_lat1);
        chk("latTwo", int'(latTwo), m_lat2);
        chk("skew", int'(skew), m_skew);
        chk("timingLeak", int'(timingLeak), int'(m_leak));
        chk("timingLeakDone", int'(timingLeakDone), int'(m_done));
        chk("resultMismatch", int'(resultMismatch), int'(m_mism));
        chk("protocolErr", int'(protocolErr), int'(m_perr));
    endtask

    // One clock cycle: drive at the falling edge, check after the next falling edge
    task automatic cyc(input bit f, input bit v1, input bit v2, input bit rdy,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        io_in_fire = f; io_out_validOne = v1; io_out_validTwo = v2; io_out_ready = rdy;
        io_out_resultOne = a; io_out_resultTwo = b;
        #1;
        chk("bothValid", int'(bothValid), int'(v1 & v2));
        model_step(f, v1 & rdy, v2 & rdy, a, b);
        @(negedge clock);
        check_model();
    endtask

    task automatic idle_inputs();
        io_in_fire = 0; io_out_validOne = 0; io_out_validTwo = 0; io_out_ready = 0;
        io_out_resultOne = '0; io_out_resultTwo = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_latOne", int'(latOne), 0);
        chk("rst_latTwo", int'(latTwo), 0);
        chk("rst_skew", int'(skew), 0);
        chk("rst_flags", int'({timingLeak, timingLeakDone, resultMismatch, protocolErr}), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_res();
        logic [W-1:0] r;
        case ($urandom_range(0, 2))
            0:       r = '0;
            1:       r = {1'b1, {(W-1){1'b0}}};
            default: r = {{(W-1){1'b0}}, 1'b1};
        endcase
        return r;
    endfunction

    typedef struct {
        int           c1;
        int           c2;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        int           lat1;
        int           lat2;
        int           skw;
        int           leak;
        int           mism;
        int           done_cyc;
    } vec_t;

    vec_t vecs[6];
    logic [W-1:0] R_A, R_ONE, R_TWO;

    initial begin
        int got;
        R_A   = {1'b1, 63'h0, 64'h1234_5678_9abc_def0};
        R_ONE = 128'h1;
        R_TWO = 128'h2;
        vecs[0] = '{5,  5, R_A,   R_A,   5,  5,  0, 0, 0, 6};
        vecs[1] = '{3,  7, R_A,   R_A,   3,  7,  4, 1, 0, 8};
        vecs[2] = '{4,  4, R_ONE, R_TWO, 4,  4,  0, 0, 1, 5};
        vecs[3] = '{-1, 2, R_A,   R_A,   66, 2,  64, 1, 0, 67};
        vecs[4] = '{-1, -1, R_A,  R_A,   0,  0,  0, 0, 0, 65};
        vecs[5] = '{7,  2, R_A,   R_A,   7,  2,  5, 1, 0, 8};

        reset = 1'b1;
        idle_inputs();
        model_clear();
        @(negedge clock);

        // Directed table: one operation per entry from a clean reset
        foreach (vecs[i]) begin
            do_reset();
            got = -1;
            for (int k = 0; k < 140; k++) begin
                cyc(k == 0, k == vecs[i].c1, k == vecs[i].c2, 1'b1, vecs[i].r1, vecs[i].r2);
                if (timingLeakDone && got < 0) got = k + 1;
            end
            chk($sformatf("v%0d_latOne", i), int'(latOne), vecs[i].lat1);
            chk($sformatf("v%0d_latTwo", i), int'(latTwo), vecs[i].lat2);
            chk($sformatf("v%0d_skew", i), int'(skew), vecs[i].skw);
            chk($sformatf("v%0d_leak", i), int'(timingLeak), vecs[i].leak);
            chk($sformatf("v%0d_mism", i), int'(resultMismatch), vecs[i].mism);
            chk($sformatf("v%0d_done_cycle", i), got, vecs[i].done_cyc);
        end

        // Leak stays set across a following matched operation
        do_reset();
        for (int k = 0; k < 6; k++) cyc(k == 0, k == 1, k == 3, 1'b1, R_A, R_A);
        for (int k = 0; k < 6; k++) cyc(k == 0, k == 2, k == 2, 1'b1, R_A, R_A);
        chk("sticky_leak", int'(timingLeak), 1);
        chk("sticky_lat", int'(latTwo), 2);
        chk("sticky_skew", int'(skew), 0);

        // Ready gating plus a stray fire mid-operation
        do_reset();
        for (int k = 0; k < 10; k++)
            cyc(k == 0 || k == 2, k >= 3 && k <= 6, k >= 3 && k <= 6, k >= 6, R_A, R_A);
        chk("gate_latOne", int'(latOne), 6);
        chk("gate_latTwo", int'(latTwo), 6);
        chk("gate_perr", int'(protocolErr), 1);
        chk("gate_done", int'(timingLeakDone), 1);

        // Asynchronous reset in the middle of WAIT_TWO, then a clean restart
        do_reset();
        for (int k = 0; k < 3; k++) cyc(k == 0, k == 2, 1'b0, 1'b1, R_A, R_A);
        chk("mid_latOne_before", int'(latOne), 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_latOne", int'(latOne), 0);
        chk("mid_rst_flags", int'({timingLeak, timingLeakDone, resultMismatch, protocolErr}), 0);
        model_clear();
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) cyc(k == 0, k == 3, k == 3, 1'b1, R_A, R_A);
        chk("restart_lat", int'(latOne), 3);
        chk("restart_leak", int'(timingLeak), 0);
        chk("restart_done", int'(timingLeakDone), 1);

        // Fire together with completions from DONE: only the fire counts
        do_reset();
        for (int k = 0; k < 4; k++) cyc(k == 0, k == 1, k == 1, 1'b1, R_A, R_A);
        for (int k = 0; k < 7; k++) cyc(k == 0, k == 0 || k == 4, k == 0 || k == 4, 1'b1, R_A, R_A);
        chk("done_fire_lat", int'(latOne), 4);
        chk("done_fire_perr", int'(protocolErr), 0);

        // Randomized traffic against the model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int k = 0; k < 400; k++)
                cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 75,
                    rnd_res(), rnd_res());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
